// File: rtl/tetris_song_axil_slave_if.sv
// AXI4-Lite bus bundle for the Tetris_Song S00_AXI port.
// master modport: drives AW/W/AR payload+valid and B/R ready.
// slave modport : drives AW/W/AR ready, B/R response, read data.
interface tetris_song_axil_slave_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/tetris_song_axil_slave.sv
// AXI4-Lite responder for the Tetris_Song IP: four 32-bit registers driving
// a square-wave tone generator and a per-note duration timer.
//   s00_axi_aclk    : clock
//   s00_axi_aresetn : synchronous active-low reset
//   s00_axi         : AXI4-Lite slave bundle (AW/W/B/AR/R)
//   tone_out        : square-wave audio output
//   irq             : DONE interrupt (only when TETRIS_SONG_IRQ_EN is defined;
//                     cleared by writing 1 to STATUS bit1)
// Register map: 0x0 CTRL (bit0 PLAY, bit1 LOOP), 0x4 HALF_PERIOD,
//               0x8 DURATION, 0xC STATUS (bit0 BUSY, bit1 DONE,
//               [31:16] remaining duration high half).
module tetris_song_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  tetris_song_axil_slave_if.slave   s00_axi,
  output logic                      tone_out
`ifdef TETRIS_SONG_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_HALF   = 2'd1;
  localparam logic [1:0] REG_DUR    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_latched_q, aw_latched_d;
  logic              w_latched_q, w_latched_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] half_period_q, half_period_d;
  logic [DATA_W-1:0] duration_q, duration_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] period_cnt_q, period_cnt_d;
  logic [DATA_W-1:0] hp_cur_q, hp_cur_d;
  logic              tone_q, tone_d;
  logic              irq_q, irq_d;

  logic              reg_wr_c;
  logic [1:0]        wr_idx_c;
  logic [DATA_W-1:0] ctrl_wval_c;
  logic              ctrl_wr_c;
  logic              play_rise_c;
  logic              play_fall_c;
  logic              done_evt_c;
  logic              hw_stop_c;
  logic              silent_c;
  logic              run_c;
  logic [DATA_W-1:0] status_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_c;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] data,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Write channel: AW and W latch independently, write fires once both are held.
  always_comb begin
    wr_state_d   = wr_state_q;
    awready_d    = 1'b0;
    wready_d     = 1'b0;
    bvalid_d     = bvalid_q;
    aw_latched_d = aw_latched_q;
    w_latched_d  = w_latched_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    reg_wr_c     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (!awready_q && s00_axi.awvalid && !aw_latched_q) awready_d = 1'b1;
        if (!wready_q && s00_axi.wvalid && !w_latched_q) wready_d = 1'b1;
        if (awready_q && s00_axi.awvalid) begin
          aw_latched_d = 1'b1;
          awaddr_d     = s00_axi.awaddr;
        end
        if (wready_q && s00_axi.wvalid) begin
          w_latched_d = 1'b1;
          wdata_d     = s00_axi.wdata;
          wstrb_d     = s00_axi.wstrb;
        end
        if (aw_latched_q && w_latched_q) begin
          reg_wr_c   = 1'b1;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s00_axi.bready) begin
          bvalid_d     = 1'b0;
          aw_latched_d = 1'b0;
          w_latched_d  = 1'b0;
          wr_state_d   = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign status_c = {remaining_q[31:16], 14'd0, done_q, busy_q};

  // Register read mux, addressed by the live AR address.
  always_comb begin
    rd_mux_c = status_c;
    case (s00_axi.araddr[3:2])
      REG_CTRL:   rd_mux_c = ctrl_q;
      REG_HALF:   rd_mux_c = half_period_q;
      REG_DUR:    rd_mux_c = duration_q;
      REG_STATUS: rd_mux_c = status_c;
      default:    rd_mux_c = status_c;
    endcase
  end

  // Read channel: independent of the write path so reads never wait on writes.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (!arready_q && s00_axi.arvalid) arready_d = 1'b1;
        if (arready_q && s00_axi.arvalid) begin
          rdata_d    = rd_mux_c;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s00_axi.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign wr_idx_c    = awaddr_q[3:2];
  assign ctrl_wr_c   = reg_wr_c && (wr_idx_c == REG_CTRL);
  assign ctrl_wval_c = apply_strb(ctrl_q, wdata_q, wstrb_q);
  assign play_rise_c = ctrl_wr_c && ctrl_wval_c[0] && !ctrl_q[0];
  assign play_fall_c = ctrl_wr_c && !ctrl_wval_c[0] && ctrl_q[0];

  // Register file and note timer; a software CTRL write overrides the hardware PLAY clear.
  always_comb begin
    ctrl_d        = ctrl_q;
    half_period_d = half_period_q;
    duration_d    = duration_q;
    remaining_d   = remaining_q;
    busy_d        = busy_q;
    done_d        = done_q;
    irq_d         = irq_q;
    done_evt_c    = 1'b0;
    hw_stop_c     = 1'b0;

    if (reg_wr_c && (wr_idx_c == REG_HALF))
      half_period_d = apply_strb(half_period_q, wdata_q, wstrb_q);
    if (reg_wr_c && (wr_idx_c == REG_DUR))
      duration_d = apply_strb(duration_q, wdata_q, wstrb_q);
`ifdef TETRIS_SONG_IRQ_EN
    if (reg_wr_c && (wr_idx_c == REG_STATUS) && wstrb_q[0] && wdata_q[1]) begin
      done_d = 1'b0;
      irq_d  = 1'b0;
    end
`endif

    if (play_rise_c) begin
      remaining_d = duration_q;
      done_d      = 1'b0;
      busy_d      = 1'b1;
    end else if (busy_q) begin
      if (play_fall_c) begin
        busy_d = 1'b0;
      end else if (remaining_q == '0) begin
        // Note started with DURATION = 0: finish immediately.
        done_evt_c = 1'b1;
        busy_d     = 1'b0;
        hw_stop_c  = 1'b1;
      end else if (remaining_q == DATA_W'(1)) begin
        done_evt_c = 1'b1;
        if (ctrl_q[1]) begin
          remaining_d = duration_q;
        end else begin
          remaining_d = '0;
          busy_d      = 1'b0;
          hw_stop_c   = 1'b1;
        end
      end else begin
        remaining_d = remaining_q - DATA_W'(1);
      end
    end

    if (done_evt_c) begin
      done_d = 1'b1;
      irq_d  = 1'b1;
    end
    if (hw_stop_c) ctrl_d[0] = 1'b0;
    if (ctrl_wr_c) ctrl_d = ctrl_wval_c;
  end

  // Silence the zero-duration note and stop the tone on the same edge PLAY drops.
  assign silent_c = (play_rise_c && (duration_q == '0)) || (busy_q && (remaining_q == '0));
  assign run_c    = ctrl_d[0] && (half_period_d != '0) && !silent_c;

  // Square-wave generator; a new HALF_PERIOD is picked up only at a wrap.
  always_comb begin
    period_cnt_d = period_cnt_q;
    hp_cur_d     = hp_cur_q;
    tone_d       = tone_q;
    if (!run_c) begin
      period_cnt_d = '0;
      tone_d       = 1'b0;
      hp_cur_d     = half_period_d;
    end else if ((hp_cur_q == '0) || (period_cnt_q >= hp_cur_q - DATA_W'(1))) begin
      period_cnt_d = '0;
      tone_d       = !tone_q;
      hp_cur_d     = half_period_d;
    end else begin
      period_cnt_d = period_cnt_q + DATA_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wr_state_q    <= WR_IDLE;
      rd_state_q    <= RD_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      aw_latched_q  <= 1'b0;
      w_latched_q   <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      ctrl_q        <= '0;
      half_period_q <= '0;
      duration_q    <= '0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      period_cnt_q  <= '0;
      hp_cur_q      <= '0;
      tone_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      aw_latched_q  <= aw_latched_d;
      w_latched_q   <= w_latched_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      ctrl_q        <= ctrl_d;
      half_period_q <= half_period_d;
      duration_q    <= duration_d;
      remaining_q   <= remaining_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      period_cnt_q  <= period_cnt_d;
      hp_cur_q      <= hp_cur_d;
      tone_q        <= tone_d;
      irq_q         <= irq_d;
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign tone_out        = tone_q;
`ifdef TETRIS_SONG_IRQ_EN
  assign irq             = irq_q;
  assign unused_c        = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.araddr[1:0], awaddr_q[1:0]};
`else
  assign unused_c        = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.araddr[1:0], awaddr_q[1:0], irq_q};
`endif

endmodule
